// File: rtl/dhcp_vlg_srv_pkg.sv
// -----------------------------------------------------------------------------
// dhcp_vlg_srv_pkg
// Shared DHCP server types: lease state, lease entry, server FSM states,
// option-53 message-type constants and a small lease helper.
// -----------------------------------------------------------------------------
package dhcp_vlg_srv_pkg;

  typedef enum logic [1:0] {
    LEASE_FREE    = 2'd0,
    LEASE_OFFERED = 2'd1,
    LEASE_BOUND   = 2'd2
  } lease_state_e;

  typedef struct packed {
    lease_state_e state;
    logic [47:0]  chaddr;
    logic [31:0]  timer;   // remaining seconds
  } lease_entry_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_DECIDE = 2'd2,
    S_SEND   = 2'd3
  } srv_state_e;

  localparam logic [7:0] MSG_DISCOVER = 8'd1;
  localparam logic [7:0] MSG_OFFER    = 8'd2;
  localparam logic [7:0] MSG_REQUEST  = 8'd3;
  localparam logic [7:0] MSG_ACK      = 8'd5;
  localparam logic [7:0] MSG_NAK      = 8'd6;
  localparam logic [7:0] MSG_RELEASE  = 8'd7;

  localparam lease_entry_t LEASE_EMPTY = '{state: LEASE_FREE, chaddr: 48'd0, timer: 32'd0};

  // An entry takes part in matching and aging only while it is not FREE.
  function automatic logic lease_live(input lease_state_e s);
    return (s != LEASE_FREE);
  endfunction

endpackage

// File: rtl/dhcp_vlg_srv_lease.sv
// -----------------------------------------------------------------------------
// dhcp_vlg_srv_lease
// Lease table with one-second prescaler and aging, one combinational read port
// and one write port. A write to an entry overrides that entry's aging in the
// same cycle. enable low flushes the table on the next edge.
// Ports:
//   clk, rst (async, active-low), enable
//   rd_idx -> rd_state, rd_chaddr   read port (out-of-range reads as FREE)
//   wr_en, wr_idx, wr_entry         write port
//   bound_cnt                       registered count of BOUND entries
// -----------------------------------------------------------------------------
module dhcp_vlg_srv_lease
  import dhcp_vlg_srv_pkg::*;
#(
  parameter int POOL_SIZE     = 8,
  parameter int TICKS_PER_SEC = 125000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic [5:0]   rd_idx,
  output lease_state_e rd_state,
  output logic [47:0]  rd_chaddr,
  input  logic         wr_en,
  input  logic [5:0]   wr_idx,
  input  lease_entry_t wr_entry,
  output logic [6:0]   bound_cnt
);

  localparam int          IW          = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;
  localparam logic [31:0] TICK_LAST_C = 32'(TICKS_PER_SEC - 1);
  localparam logic [6:0]  POOL_SIZE_C = 7'(POOL_SIZE);

  lease_entry_t lease_r [POOL_SIZE];
  logic [31:0]  presc_r;
  logic         tick_s;
  logic [6:0]   bound_cnt_s;
  logic [6:0]   bound_cnt_r;

  assign tick_s    = (presc_r == TICK_LAST_C);
  assign bound_cnt = bound_cnt_r;

  // One-second prescaler; held at zero while the server is disabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_r <= 32'd0;
    end else if (!enable || tick_s) begin
      presc_r <= 32'd0;
    end else begin
      presc_r <= presc_r + 32'd1;
    end
  end

  // Lease table: flush, FSM write (wins over aging), then per-second aging.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < POOL_SIZE; i++) lease_r[i] <= LEASE_EMPTY;
    end else if (!enable) begin
      for (int i = 0; i < POOL_SIZE; i++) lease_r[i] <= LEASE_EMPTY;
    end else begin
      for (int i = 0; i < POOL_SIZE; i++) begin
        if (wr_en && (wr_idx == 6'(i))) begin
          lease_r[i] <= wr_entry;
        end else if (tick_s && lease_live(lease_r[i].state)) begin
          // A live timer at 1 (or a corrupt 0) expires instead of wrapping.
          if (lease_r[i].timer <= 32'd1) begin
            lease_r[i] <= LEASE_EMPTY;
          end else begin
            lease_r[i].timer <= lease_r[i].timer - 32'd1;
          end
        end
      end
    end
  end

  // Read port; indices past the pool read as an empty FREE entry.
  always_comb begin
    if ({1'b0, rd_idx} < POOL_SIZE_C) begin
      rd_state  = lease_r[rd_idx[IW-1:0]].state;
      rd_chaddr = lease_r[rd_idx[IW-1:0]].chaddr;
    end else begin
      rd_state  = LEASE_FREE;
      rd_chaddr = 48'd0;
    end
  end

  // Population count of BOUND entries.
  always_comb begin
    bound_cnt_s = 7'd0;
    for (int i = 0; i < POOL_SIZE; i++) begin
      bound_cnt_s = bound_cnt_s + {6'd0, (lease_r[i].state == LEASE_BOUND)};
    end
  end

  // Registered BOUND count, one cycle behind the table.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bound_cnt_r <= 7'd0;
    end else begin
      bound_cnt_r <= bound_cnt_s;
    end
  end

endmodule

// File: rtl/dhcp_vlg_srv_core.sv
// -----------------------------------------------------------------------------
// dhcp_vlg_srv_core
// DHCP server decision core. Latches a parsed DHCP message, scans the lease
// table (one entry per cycle), decides OFFER / ACK / NAK / silent update and
// presents the reply on a valid/ready interface to the serializer.
// Ports:
//   clk, rst (async, active-low), enable (low: flush table, ignore rx)
//   rx_val + rx_* : parsed request (msg type, xid, chaddr, ciaddr, opt50, opt54)
//   tx_val/tx_rdy + tx_* : reply fields, held until accepted
//   rx_drop   : pulse when a request arrives while busy
//   bound_cnt : number of BOUND leases
// -----------------------------------------------------------------------------
module dhcp_vlg_srv_core
  import dhcp_vlg_srv_pkg::*;
#(
  parameter logic [31:0] SERVER_IP     = 32'hC0A80001,
  parameter logic [31:0] POOL_BASE     = 32'hC0A8000A,
  parameter int          POOL_SIZE     = 8,
  parameter logic [31:0] LEASE_TIME    = 32'd3600,
  parameter logic [31:0] OFFER_TIMEOUT = 32'd10,
  parameter int          TICKS_PER_SEC = 125000000,
  parameter int          VERBOSE       = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        rx_val,
  input  logic [7:0]  rx_msg_type,
  input  logic [31:0] rx_xid,
  input  logic [47:0] rx_chaddr,
  input  logic [31:0] rx_ciaddr,
  input  logic [31:0] rx_req_ip,
  input  logic        rx_req_ip_pres,
  input  logic [31:0] rx_srv_id,
  input  logic        rx_srv_id_pres,
  output logic        tx_val,
  input  logic        tx_rdy,
  output logic [7:0]  tx_msg_type,
  output logic [31:0] tx_xid,
  output logic [47:0] tx_chaddr,
  output logic [31:0] tx_yiaddr,
  output logic [31:0] tx_lease,
  output logic        rx_drop,
  output logic [6:0]  bound_cnt
);

  localparam logic [5:0]  SCAN_LAST_C = 6'(POOL_SIZE - 1);
  localparam logic [31:0] POOL_SZ32_C = 32'(POOL_SIZE);

  // Decisions are visible on the tx_* ports; VERBOSE is kept so the server
  // shares the client core's parameter set, and has no hardware effect.
  if (VERBOSE != 0) begin : g_verbose
  end

  srv_state_e   state_r, state_nxt_s;
  logic [5:0]   scan_idx_r;
  logic         hit_r, free_r;
  logic [5:0]   hit_idx_r, free_idx_r;

  logic [7:0]   msg_r;
  logic [31:0]  xid_r, ciaddr_r, req_ip_r, srv_id_r;
  logic [47:0]  chaddr_r;
  logic         req_pres_r, srv_pres_r;

  logic         tx_val_r, rx_drop_r;
  logic [7:0]   tx_msg_type_r;
  logic [31:0]  tx_xid_r, tx_yiaddr_r, tx_lease_r;
  logic [47:0]  tx_chaddr_r;

  logic [5:0]   rd_idx_s;
  lease_state_e rd_state_s;
  logic [47:0]  rd_chaddr_s;
  logic         wr_en_s;
  logic [5:0]   wr_idx_s;
  lease_entry_t wr_entry_s;

  logic [5:0]   target_idx_s;
  logic [31:0]  req_s, off_s;
  logic         off_ok_s, srv_other_s;
  logic         reply_s;
  logic [7:0]   reply_type_s;
  logic [31:0]  reply_yiaddr_s, reply_lease_s;

  assign target_idx_s = hit_r ? hit_idx_r : free_idx_r;
  assign req_s        = req_pres_r ? req_ip_r : ciaddr_r;
  assign off_s        = req_s - POOL_BASE;   // wraps for addresses below the pool
  assign off_ok_s     = (off_s < POOL_SZ32_C);
  assign srv_other_s  = srv_pres_r && (srv_id_r != SERVER_IP);

  dhcp_vlg_srv_lease #(
    .POOL_SIZE     (POOL_SIZE),
    .TICKS_PER_SEC (TICKS_PER_SEC)
  ) u_lease (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .rd_idx    (rd_idx_s),
    .rd_state  (rd_state_s),
    .rd_chaddr (rd_chaddr_s),
    .wr_en     (wr_en_s),
    .wr_idx    (wr_idx_s),
    .wr_entry  (wr_entry_s),
    .bound_cnt (bound_cnt)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state, table read/write port and reply decision.
  always_comb begin
    state_nxt_s    = state_r;
    rd_idx_s       = scan_idx_r;
    wr_en_s        = 1'b0;
    wr_idx_s       = target_idx_s;
    wr_entry_s     = LEASE_EMPTY;
    reply_s        = 1'b0;
    reply_type_s   = MSG_NAK;
    reply_yiaddr_s = 32'd0;
    reply_lease_s  = 32'd0;
    if (!enable) begin
      state_nxt_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (rx_val) state_nxt_s = S_SCAN;
          else        state_nxt_s = S_IDLE;
        end
        S_SCAN: begin
          if (scan_idx_r == SCAN_LAST_C) state_nxt_s = S_DECIDE;
          else                           state_nxt_s = S_SCAN;
        end
        S_DECIDE: begin
          state_nxt_s = S_IDLE;
          rd_idx_s    = target_idx_s;
          case (msg_r)
            MSG_DISCOVER: begin
              if (hit_r || free_r) begin
                reply_s        = 1'b1;
                reply_type_s   = MSG_OFFER;
                reply_yiaddr_s = POOL_BASE + {26'd0, target_idx_s};
                reply_lease_s  = LEASE_TIME;
                state_nxt_s    = S_SEND;
                // A BOUND client re-discovering keeps its binding untouched.
                if (rd_state_s != LEASE_BOUND) begin
                  wr_en_s    = 1'b1;
                  wr_entry_s = '{state: LEASE_OFFERED, chaddr: chaddr_r, timer: OFFER_TIMEOUT};
                end else begin
                  wr_en_s    = 1'b0;
                end
              end else begin
                state_nxt_s = S_IDLE;
              end
            end
            MSG_REQUEST: begin
              if (srv_other_s) begin
                // Client picked another server: release our pending offer silently.
                if (hit_r && (rd_state_s == LEASE_OFFERED)) wr_en_s = 1'b1;
                else                                        wr_en_s = 1'b0;
              end else begin
                rd_idx_s    = off_s[5:0];
                state_nxt_s = S_SEND;
                reply_s     = 1'b1;
                if (off_ok_s && (rd_chaddr_s == chaddr_r) && lease_live(rd_state_s)) begin
                  wr_en_s        = 1'b1;
                  wr_idx_s       = off_s[5:0];
                  wr_entry_s     = '{state: LEASE_BOUND, chaddr: chaddr_r, timer: LEASE_TIME};
                  reply_type_s   = MSG_ACK;
                  reply_yiaddr_s = req_s;
                  reply_lease_s  = LEASE_TIME;
                end else begin
                  reply_type_s   = MSG_NAK;
                end
              end
            end
            MSG_RELEASE: begin
              if (hit_r && (rd_state_s == LEASE_BOUND)) wr_en_s = 1'b1;
              else                                      wr_en_s = 1'b0;
            end
            default: begin
              state_nxt_s = S_IDLE;
            end
          endcase
        end
        S_SEND: begin
          if (tx_rdy) state_nxt_s = S_IDLE;
          else        state_nxt_s = S_SEND;
        end
        default: begin
          state_nxt_s = S_IDLE;
        end
      endcase
    end
  end

  // Request latch and scan bookkeeping (first live MAC match, first FREE slot).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      msg_r      <= 8'd0;
      xid_r      <= 32'd0;
      chaddr_r   <= 48'd0;
      ciaddr_r   <= 32'd0;
      req_ip_r   <= 32'd0;
      req_pres_r <= 1'b0;
      srv_id_r   <= 32'd0;
      srv_pres_r <= 1'b0;
      scan_idx_r <= 6'd0;
      hit_r      <= 1'b0;
      hit_idx_r  <= 6'd0;
      free_r     <= 1'b0;
      free_idx_r <= 6'd0;
    end else if (enable && (state_r == S_IDLE) && rx_val) begin
      msg_r      <= rx_msg_type;
      xid_r      <= rx_xid;
      chaddr_r   <= rx_chaddr;
      ciaddr_r   <= rx_ciaddr;
      req_ip_r   <= rx_req_ip;
      req_pres_r <= rx_req_ip_pres;
      srv_id_r   <= rx_srv_id;
      srv_pres_r <= rx_srv_id_pres;
      scan_idx_r <= 6'd0;
      hit_r      <= 1'b0;
      free_r     <= 1'b0;
    end else if (state_r == S_SCAN) begin
      scan_idx_r <= scan_idx_r + 6'd1;
      if (!hit_r && lease_live(rd_state_s) && (rd_chaddr_s == chaddr_r)) begin
        hit_r     <= 1'b1;
        hit_idx_r <= scan_idx_r;
      end
      if (!free_r && !lease_live(rd_state_s)) begin
        free_r     <= 1'b1;
        free_idx_r <= scan_idx_r;
      end
    end
  end

  // Reply registers: loaded in DECIDE, held until the first edge with tx_rdy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_val_r      <= 1'b0;
      tx_msg_type_r <= 8'd0;
      tx_xid_r      <= 32'd0;
      tx_chaddr_r   <= 48'd0;
      tx_yiaddr_r   <= 32'd0;
      tx_lease_r    <= 32'd0;
    end else if (!enable) begin
      tx_val_r      <= 1'b0;
    end else if (reply_s) begin
      tx_val_r      <= 1'b1;
      tx_msg_type_r <= reply_type_s;
      tx_xid_r      <= xid_r;
      tx_chaddr_r   <= chaddr_r;
      tx_yiaddr_r   <= reply_yiaddr_s;
      tx_lease_r    <= reply_lease_s;
    end else if ((state_r == S_SEND) && tx_rdy) begin
      tx_val_r      <= 1'b0;
    end
  end

  // Busy-drop pulse for requests arriving outside IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_drop_r <= 1'b0;
    end else begin
      rx_drop_r <= enable && rx_val && (state_r != S_IDLE);
    end
  end

  assign tx_val      = tx_val_r;
  assign tx_msg_type = tx_msg_type_r;
  assign tx_xid      = tx_xid_r;
  assign tx_chaddr   = tx_chaddr_r;
  assign tx_yiaddr   = tx_yiaddr_r;
  assign tx_lease    = tx_lease_r;
  assign rx_drop     = rx_drop_r;

endmodule

// File: tb/tb_dhcp_vlg_srv_core.sv
// Directed, table-driven bench for dhcp_vlg_srv_core (POOL_SIZE 8, short second).
module tb_dhcp_vlg_srv_core;
  import dhcp_vlg_srv_pkg::*;

  localparam int          PS   = 8;
  localparam int          TPS  = 1000;
  localparam logic [31:0] SRV  = 32'hC0A80001;
  localparam logic [31:0] NET  = 32'hC0A80000;
  localparam logic [31:0] LT   = 32'd3600;
  localparam int          LAT  = PS + 1;   // posedges after the sampling edge
  localparam logic [47:0] MAC1 = 48'h020000000001;
  localparam logic [47:0] MAC2 = 48'h020000000002;
  localparam logic [47:0] MAC3 = 48'h020000000003;

  logic        clk = 1'b0, rst = 1'b0, enable = 1'b1;
  logic        rx_val = 1'b0, rx_req_ip_pres = 1'b0, rx_srv_id_pres = 1'b0, tx_rdy = 1'b0;
  logic [7:0]  rx_msg_type = 8'd0;
  logic [31:0] rx_xid = 32'd0, rx_ciaddr = 32'd0, rx_req_ip = 32'd0, rx_srv_id = 32'd0;
  logic [47:0] rx_chaddr = 48'd0;
  logic        tx_val, rx_drop;
  logic [7:0]  tx_msg_type;
  logic [31:0] tx_xid, tx_yiaddr, tx_lease;
  logic [47:0] tx_chaddr;
  logic [6:0]  bound_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dhcp_vlg_srv_core #(
    .POOL_SIZE(PS), .TICKS_PER_SEC(TPS), .VERBOSE(0)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .rx_val(rx_val), .rx_msg_type(rx_msg_type), .rx_xid(rx_xid), .rx_chaddr(rx_chaddr),
    .rx_ciaddr(rx_ciaddr), .rx_req_ip(rx_req_ip), .rx_req_ip_pres(rx_req_ip_pres),
    .rx_srv_id(rx_srv_id), .rx_srv_id_pres(rx_srv_id_pres),
    .tx_val(tx_val), .tx_rdy(tx_rdy), .tx_msg_type(tx_msg_type), .tx_xid(tx_xid),
    .tx_chaddr(tx_chaddr), .tx_yiaddr(tx_yiaddr), .tx_lease(tx_lease),
    .rx_drop(rx_drop), .bound_cnt(bound_cnt)
  );

  typedef struct {
    logic [7:0]  msg;
    logic [31:0] xid;
    logic [47:0] mac;
    logic [31:0] ciaddr;
    logic [31:0] req_ip;
    logic        req_pres;
    logic [31:0] srv_id;
    logic        srv_pres;
    logic        exp_reply;
    logic [7:0]  exp_type;
    logic [31:0] exp_yiaddr;
    logic [31:0] exp_lease;
    logic [6:0]  exp_bound;
  } vec_t;

  vec_t vecs [12];

  function automatic vec_t mk(input logic [7:0] msg, input logic [31:0] xid, input logic [47:0] mac,
                              input logic [31:0] ciaddr, input logic [31:0] req_ip, input logic req_pres,
                              input logic [31:0] srv_id, input logic srv_pres, input logic exp_reply,
                              input logic [7:0] exp_type, input logic [31:0] exp_yiaddr,
                              input logic [31:0] exp_lease, input logic [6:0] exp_bound);
    vec_t v;
    v.msg = msg; v.xid = xid; v.mac = mac; v.ciaddr = ciaddr; v.req_ip = req_ip;
    v.req_pres = req_pres; v.srv_id = srv_id; v.srv_pres = srv_pres; v.exp_reply = exp_reply;
    v.exp_type = exp_type; v.exp_yiaddr = exp_yiaddr; v.exp_lease = exp_lease; v.exp_bound = exp_bound;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
  endtask

  // One-cycle rx strobe; returns on the negedge after the sampling posedge.
  task automatic send_rx(input vec_t v);
    @(negedge clk);
    rx_val = 1'b1; rx_msg_type = v.msg; rx_xid = v.xid; rx_chaddr = v.mac; rx_ciaddr = v.ciaddr;
    rx_req_ip = v.req_ip; rx_req_ip_pres = v.req_pres; rx_srv_id = v.srv_id; rx_srv_id_pres = v.srv_pres;
    @(negedge clk);
    rx_val = 1'b0;
  endtask

  task automatic txn(input vec_t v, input string name);
    bit got = 1'b0;
    int lat = 0;
    send_rx(v);
    for (int n = 1; n <= PS + 6; n++) begin
      @(posedge clk); #1;
      if (!got && tx_val) begin got = 1'b1; lat = n; end
    end
    check({name, ".reply"}, 64'(got), 64'(v.exp_reply));
    if (got) begin
      if (v.exp_reply) begin
        check({name, ".latency"}, 64'(lat), 64'(LAT));
        check({name, ".type"},    64'(tx_msg_type), 64'(v.exp_type));
        check({name, ".xid"},     64'(tx_xid),      64'(v.xid));
        check({name, ".chaddr"},  64'(tx_chaddr),   64'(v.mac));
        check({name, ".yiaddr"},  64'(tx_yiaddr),   64'(v.exp_yiaddr));
        if (v.exp_type != MSG_OFFER) check({name, ".lease"}, 64'(tx_lease), 64'(v.exp_lease));
      end
      @(negedge clk); tx_rdy = 1'b1;
      @(posedge clk); #1;
      check({name, ".tx_val_fall"}, 64'(tx_val), 64'd0);
      @(negedge clk); tx_rdy = 1'b0;
    end
    @(negedge clk);
    check({name, ".bound_cnt"}, 64'(bound_cnt), 64'(v.exp_bound));
  endtask

  initial begin
    vec_t v;
    bit   got;
    //               msg          xid     mac   ciaddr     req_ip       rp    srv_id          sp    rep   type       yiaddr      lease  bnd
    vecs[0]  = mk(MSG_DISCOVER, 32'h1234, MAC1, 32'd0,     32'd0,       1'b0, 32'd0,          1'b0, 1'b1, MSG_OFFER, NET+32'd10, LT,    7'd0);
    vecs[1]  = mk(MSG_REQUEST,  32'h1235, MAC1, 32'd0,     NET+32'd10,  1'b1, SRV,            1'b1, 1'b1, MSG_ACK,   NET+32'd10, LT,    7'd1);
    vecs[2]  = mk(MSG_DISCOVER, 32'h2000, MAC1, 32'd0,     32'd0,       1'b0, 32'd0,          1'b0, 1'b1, MSG_OFFER, NET+32'd10, LT,    7'd1);
    vecs[3]  = mk(MSG_DISCOVER, 32'h2001, MAC2, 32'd0,     32'd0,       1'b0, 32'd0,          1'b0, 1'b1, MSG_OFFER, NET+32'd11, LT,    7'd1);
    vecs[4]  = mk(MSG_REQUEST,  32'h2002, MAC2, 32'd0,     NET+32'd11,  1'b1, NET+32'd2,      1'b1, 1'b0, MSG_NAK,   32'd0,      32'd0, 7'd1);
    vecs[5]  = mk(MSG_REQUEST,  32'h2003, MAC2, 32'd0,     NET+32'd11,  1'b1, SRV,            1'b1, 1'b1, MSG_NAK,   32'd0,      32'd0, 7'd1);
    vecs[6]  = mk(MSG_REQUEST,  32'h2004, MAC1, 32'd0,     NET+32'd30,  1'b1, SRV,            1'b1, 1'b1, MSG_NAK,   32'd0,      32'd0, 7'd1);
    vecs[7]  = mk(MSG_REQUEST,  32'h2005, MAC3, 32'd0,     NET+32'd10,  1'b1, SRV,            1'b1, 1'b1, MSG_NAK,   32'd0,      32'd0, 7'd1);
    vecs[8]  = mk(MSG_REQUEST,  32'h2006, MAC1, NET+32'd10, 32'd0,      1'b0, 32'd0,          1'b0, 1'b1, MSG_ACK,   NET+32'd10, LT,    7'd1);
    vecs[9]  = mk(MSG_RELEASE,  32'h2007, MAC1, NET+32'd10, 32'd0,      1'b0, SRV,            1'b1, 1'b0, MSG_NAK,   32'd0,      32'd0, 7'd0);
    vecs[10] = mk(MSG_DISCOVER, 32'h2008, MAC3, 32'd0,     32'd0,       1'b0, 32'd0,          1'b0, 1'b1, MSG_OFFER, NET+32'd10, LT,    7'd0);
    vecs[11] = mk(8'd8,         32'h2009, MAC1, 32'd0,     32'd0,       1'b0, 32'd0,          1'b0, 1'b0, MSG_NAK,   32'd0,      32'd0, 7'd0);

    // Reset values while rst is held low.
    repeat (3) @(posedge clk);
    #1;
    check("rst.tx_val", 64'(tx_val), 64'd0);
    check("rst.tx_type", 64'(tx_msg_type), 64'd0);
    check("rst.tx_xid", 64'(tx_xid), 64'd0);
    check("rst.tx_chaddr", 64'(tx_chaddr), 64'd0);
    check("rst.tx_yiaddr", 64'(tx_yiaddr), 64'd0);
    check("rst.tx_lease", 64'(tx_lease), 64'd0);
    check("rst.rx_drop", 64'(rx_drop), 64'd0);
    check("rst.bound_cnt", 64'(bound_cnt), 64'd0);
    @(negedge clk); rst = 1'b1;

    // Table-driven protocol sequence (state carries from vector to vector).
    for (int i = 0; i < 12; i++) txn(vecs[i], $sformatf("vec%0d", i));

    // Pool exhaustion, then offer aging.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      v = mk(MSG_DISCOVER, 32'h3000 + 32'(i), 48'h020000000100 + 48'(i), 32'd0, 32'd0, 1'b0, 32'd0, 1'b0,
             (i < 8), MSG_OFFER, NET + 32'd10 + 32'(i), LT, 7'd0);
      txn(v, $sformatf("pool%0d", i));
    end
    repeat (11 * TPS) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      v = mk(MSG_REQUEST, 32'h3100 + 32'(i), 48'h020000000100 + 48'(i), 32'd0, NET + 32'd10 + 32'(i), 1'b1,
             SRV, 1'b1, 1'b1, MSG_NAK, 32'd0, 32'd0, 7'd0);
      txn(v, $sformatf("aged%0d", i));
    end

    // Held reply with busy drop, then asynchronous reset mid-SEND.
    do_reset();
    txn(vecs[0], "hold.disc");
    txn(vecs[1], "hold.req");
    v = mk(MSG_DISCOVER, 32'h4444, MAC2, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, MSG_OFFER, NET+32'd11, LT, 7'd1);
    send_rx(v);
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(posedge clk); #1;
      got = tx_val;
    end
    check("hold.reply", 64'(got), 64'd1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      rx_val = (k == 5);
      @(posedge clk); #1;
      check("hold.tx_val", 64'(tx_val), 64'd1);
      check("hold.yiaddr", 64'(tx_yiaddr), 64'(NET + 32'd11));
      check("hold.xid", 64'(tx_xid), 64'h4444);
      check("hold.chaddr", 64'(tx_chaddr), 64'(MAC2));
      check("hold.type", 64'(tx_msg_type), 64'(MSG_OFFER));
      if (k == 5) check("hold.rx_drop", 64'(rx_drop), 64'd1);
      if (k == 6) check("hold.rx_drop_end", 64'(rx_drop), 64'd0);
    end
    @(negedge clk);
    rx_val = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("arst.tx_val", 64'(tx_val), 64'd0);
    check("arst.yiaddr", 64'(tx_yiaddr), 64'd0);
    check("arst.bound_cnt", 64'(bound_cnt), 64'd0);
    @(negedge clk); rst = 1'b1;
    v = mk(MSG_REQUEST, 32'h4445, MAC1, NET+32'd10, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, MSG_NAK, 32'd0, 32'd0, 7'd0);
    txn(v, "arst.empty");

    // enable low flushes the table.
    txn(vecs[0], "en.disc");
    txn(vecs[1], "en.req");
    @(negedge clk); enable = 1'b0;
    @(negedge clk); enable = 1'b1;
    @(negedge clk);
    check("en.bound_cnt", 64'(bound_cnt), 64'd0);
    v = mk(MSG_REQUEST, 32'h5000, MAC1, 32'd0, NET+32'd10, 1'b1, SRV, 1'b1, 1'b1, MSG_NAK, 32'd0, 32'd0, 7'd0);
    txn(v, "en.flushed");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
